instruction_encoder: RTL

Streaming MIPS instruction encoder: accepts decoded field bundles (format, opcode, register indices, shamt, funct, immediate, jump target) over a valid/ready handshake, packs them into 32-bit R/I/J instruction words, and emits each word with a sequential word address toward instruction-memory load logic. It is the write-side counterpart of the R/I/J instruction decoders. It loads programs into instruction memory and generates decoder test vectors.

---
 rtl/mips_pkg.sv | 45 ++++
 rtl/instruction_encoder_if.sv | 40 ++++
 rtl/instruction_format_packer.sv | 42 ++++
 rtl/instruction_encoder.sv | 112 +++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS encoding definitions: format codes, field positions,
// common opcodes and the bundle struct used by the encoder.
package mips_pkg;

  typedef enum logic [1:0] {
    FMT_R   = 2'b00,
    FMT_I   = 2'b01,
    FMT_J   = 2'b10,
    FMT_BAD = 2'b11
  } fmt_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int OP_LSB  = 26;
  localparam int RS_LSB  = 21;
  localparam int RT_LSB  = 16;
  localparam int RD_LSB  = 11;
  localparam int SH_LSB  = 6;
  localparam int FN_LSB  = 0;
  localparam int IMM_LSB = 0;
  localparam int TGT_LSB = 0;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] FN_ADD   = 6'h20;

  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  typedef struct packed {
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic [25:0] target;
  } fields_t;

endpackage

// File: rtl/instruction_encoder_if.sv
// Field-bundle input and encoded-word output handshakes of the
// instruction encoder; master drives bundles, slave is the encoder.
interface instruction_encoder_if #(
  parameter int ADDR_WIDTH = 10
);

  logic                  in_valid;
  logic                  in_ready;
  logic                  in_last;
  logic [1:0]            fmt;
  logic [5:0]            opcode;
  logic [4:0]            rs;
  logic [4:0]            rt;
  logic [4:0]            rd;
  logic [4:0]            shamt;
  logic [5:0]            funct;
  logic [15:0]           imm;
  logic [25:0]           target;
  logic                  out_valid;
  logic                  out_ready;
  logic [31:0]           out_instr;
  logic [ADDR_WIDTH-1:0] out_addr;

  modport master (
    output in_valid, in_last, fmt, opcode,
    output rs, rt, rd, shamt, funct,
    output imm, target, out_ready,
    input  in_ready, out_valid,
    input  out_instr, out_addr
  );

  modport slave (
    input  in_valid, in_last, fmt, opcode,
    input  rs, rt, rd, shamt, funct,
    input  imm, target, out_ready,
    output in_ready, out_valid,
    output out_instr, out_addr
  );

endinterface

// File: rtl/instruction_format_packer.sv
// Combinational R/I/J packer: fields + format -> 32-bit word.
// Illegal format yields the NOP word and raises illegal.
module instruction_format_packer
  import mips_pkg::*;
(
  input  fmt_t        fmt,
  input  fields_t     fields,
  output logic [31:0] word,
  output logic        illegal
);

  // pack the fields selected by the format
  always_comb begin
    word    = '0;
    illegal = 1'b0;
    unique case (1'b1)
      fmt == FMT_R: begin
        word[OP_LSB +: 6] = fields.opcode;
        word[RS_LSB +: 5] = fields.rs;
        word[RT_LSB +: 5] = fields.rt;
        word[RD_LSB +: 5] = fields.rd;
        word[SH_LSB +: 5] = fields.shamt;
        word[FN_LSB +: 6] = fields.funct;
      end
      fmt == FMT_I: begin
        word[OP_LSB +: 6]   = fields.opcode;
        word[RS_LSB +: 5]   = fields.rs;
        word[RT_LSB +: 5]   = fields.rt;
        word[IMM_LSB +: 16] = fields.imm;
      end
      fmt == FMT_J: begin
        word[OP_LSB +: 6]   = fields.opcode;
        word[TGT_LSB +: 26] = fields.target;
      end
      default: begin
        word    = NOP_WORD;
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/instruction_encoder.sv
// Streaming MIPS instruction encoder: accepts field bundles, emits
// packed words with sequential word addresses toward imem load logic.
module instruction_encoder
  import mips_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  instruction_encoder_if.slave  bus,
  output logic                  busy,
  output logic                  err,
  output logic                  full
);

  localparam logic [ADDR_WIDTH-1:0] BASE =
    ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] LAST = '1;

  state_t                state;
  state_t                state_nxt;
  logic [ADDR_WIDTH-1:0] addr;
  fields_t               fields;
  logic [31:0]           word;
  logic                  illegal;
  logic                  accept;
  logic                  at_end;
  logic                  restart;

  assign fields = '{
    opcode: bus.opcode,
    rs:     bus.rs,
    rt:     bus.rt,
    rd:     bus.rd,
    shamt:  bus.shamt,
    funct:  bus.funct,
    imm:    bus.imm,
    target: bus.target
  };

  assign accept  = bus.in_valid && bus.in_ready;
  assign at_end  = addr == LAST;
  assign restart = start && (state != S_RUN);

  instruction_format_packer u_packer (
    .fmt     (fmt_t'(bus.fmt)),
    .fields  (fields),
    .word    (word),
    .illegal (illegal)
  );

  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // next state: the last bundle or the top address ends the program
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: if (start) state_nxt = S_RUN;
      S_RUN:
        if (accept && (bus.in_last || at_end))
          state_nxt = S_DONE;
      S_DONE: if (start) state_nxt = S_RUN;
      default: state_nxt = S_IDLE;
    endcase
  end

  // outputs: in_ready follows out_ready combinationally
  always_comb begin
    busy         = state == S_RUN;
    bus.in_ready = (state == S_RUN) &&
                   (!bus.out_valid || bus.out_ready);
  end

  // address counter and sticky flags; counter holds at the top
  always_ff @(posedge clk) begin
    if (reset) begin
      addr <= BASE;
      err  <= 1'b0;
      full <= 1'b0;
    end else if (restart) begin
      addr <= BASE;
      err  <= 1'b0;
      full <= 1'b0;
    end else if (accept) begin
      if (illegal) err <= 1'b1;
      if (at_end) full <= 1'b1;
      else        addr <= addr + ADDR_WIDTH'(1);
    end
  end

  // output register: reload on accept, clear once consumed
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.out_valid <= 1'b0;
      bus.out_instr <= '0;
      bus.out_addr  <= BASE;
    end else if (accept) begin
      bus.out_valid <= 1'b1;
      bus.out_instr <= word;
      bus.out_addr  <= addr;
    end else if (bus.out_valid && bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end

endmodule
